sram_access_seq: RTL

Initiator-side sequencer for the tester's external SRAM bank (four 71V016-class 64Kx16 chips sharing strobes, 64-bit word). It accepts read and write burst commands from tester logic and generates the active-low OE/CS/WE requests, address and data-bus direction. Its strobe outputs feed the registered SRAM strobe stage, which adds one cycle of delay. All strobe timing below accounts for that extra cycle.

---
 rtl/sram_access_seq.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/sram_access_seq.sv
// sram_access_seq
//   Initiator-side burst sequencer for the external SRAM bank (four 64Kx16
//   chips sharing strobes, 64-bit word). It accepts read/write burst
//   commands and drives the active-low strobe requests, the address and the
//   data-bus direction. The strobe outputs feed a registered strobe stage
//   that adds one cycle of delay. The W_HOLD length and the read wait
//   account for that extra cycle.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   CMD_VALID/READY/WR/ADDR/LEN  burst command handshake (READY only in IDLE)
//   WDATA, WDATA_VALID/READY     write word handshake (READY only in W_WAIT)
//   RDATA, RDATA_VALID           captured read word, one-cycle pulse per word
//   DONE                         one-cycle pulse at burst completion
//   DQ_IN, DQ_OUT, DQ_OE         SRAM data bus in / out / drive enable
//   ADDR                         SRAM word address
//   OE_BAR_OUT, CS_BAR_OUT, WE_BAR_OUT  strobe requests (active low)
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a command, CMD_READY=1
// W_WAIT   | waiting for the next write word, WDATA_READY=1
// W_SETUP  | address and data driven, CS low, WE still high
// W_PULSE  | WE low for WR_PULSE_CYC cycles
// W_HOLD   | WE high again, address/data held for 2 cycles
// R_SETUP  | address driven, CS and OE low
// R_WAIT   | RD_WAIT_CYC cycles of access time, DQ_IN captured at the end
// R_NEXT   | RDATA_VALID pulse, advance to the next word
// DONE     | strobes released, DONE pulse
module sram_access_seq #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 64,
  parameter int WR_PULSE_CYC = 2,
  parameter int RD_WAIT_CYC  = 3,
  parameter int LEN_W        = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WR,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [LEN_W-1:0]  CMD_LEN,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WDATA_VALID,
  output logic              WDATA_READY,
  output logic [DATA_W-1:0] RDATA,
  output logic              RDATA_VALID,
  output logic              DONE,
  input  logic [DATA_W-1:0] DQ_IN,
  output logic [DATA_W-1:0] DQ_OUT,
  output logic              DQ_OE,
  output logic [ADDR_W-1:0] ADDR,
  output logic              OE_BAR_OUT,
  output logic              CS_BAR_OUT,
  output logic              WE_BAR_OUT
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_WAIT, S_W_SETUP, S_W_PULSE, S_W_HOLD,
    S_R_SETUP, S_R_WAIT, S_R_NEXT, S_DONE
  } state_t;

  // The timer must hold WR_PULSE_CYC-1, RD_WAIT_CYC-1 and the hold count of 1.
  localparam int TMR_MAX = (WR_PULSE_CYC > RD_WAIT_CYC) ?
                           ((WR_PULSE_CYC > 2) ? WR_PULSE_CYC : 2) :
                           ((RD_WAIT_CYC > 2) ? RD_WAIT_CYC : 2);
  localparam int TMR_W   = $clog2(TMR_MAX);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  rem;
  logic [TMR_W-1:0]  tmr;
  logic [ADDR_W-1:0] addr_inc;
  logic              last_word;
  logic              tmr_tc;

  // Address wraps modulo 2^ADDR_W by plain overflow.
  assign addr_inc  = addr + ADDR_W'(1);
  assign last_word = (rem == LEN_W'(1));
  assign tmr_tc    = (tmr == '0);

  // All outputs are registered together with the state: each branch sets the
  // outputs that belong to the state being entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      addr        <= '0;
      rem         <= '0;
      tmr         <= '0;
      CMD_READY   <= 1'b1;
      WDATA_READY <= 1'b0;
      RDATA       <= '0;
      RDATA_VALID <= 1'b0;
      DONE        <= 1'b0;
      DQ_OUT      <= '0;
      DQ_OE       <= 1'b0;
      ADDR        <= '0;
      OE_BAR_OUT  <= 1'b1;
      CS_BAR_OUT  <= 1'b1;
      WE_BAR_OUT  <= 1'b1;
    end else begin
      DONE        <= 1'b0;
      RDATA_VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (CMD_VALID) begin
            addr      <= CMD_ADDR;
            rem       <= CMD_LEN;
            CMD_READY <= 1'b0;
            if (CMD_LEN == '0) begin
              state <= S_DONE;
              DONE  <= 1'b1;
            end else if (CMD_WR) begin
              state       <= S_W_WAIT;
              WDATA_READY <= 1'b1;
            end else begin
              state      <= S_R_SETUP;
              ADDR       <= CMD_ADDR;
              CS_BAR_OUT <= 1'b0;
              OE_BAR_OUT <= 1'b0;
            end
          end
        end

        // Strobes keep their previous values here, so CS stays low and the
        // bus stays driven across stalls between words of a burst.
        S_W_WAIT: begin
          if (WDATA_VALID) begin
            state       <= S_W_SETUP;
            WDATA_READY <= 1'b0;
            DQ_OUT      <= WDATA;
            DQ_OE       <= 1'b1;
            CS_BAR_OUT  <= 1'b0;
            ADDR        <= addr;
          end
        end

        S_W_SETUP: begin
          state      <= S_W_PULSE;
          WE_BAR_OUT <= 1'b0;
          tmr        <= TMR_W'(WR_PULSE_CYC - 1);
        end

        S_W_PULSE: begin
          if (tmr_tc) begin
            state      <= S_W_HOLD;
            WE_BAR_OUT <= 1'b1;
            tmr        <= TMR_W'(1);
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        S_W_HOLD: begin
          if (tmr_tc) begin
            addr <= addr_inc;
            rem  <= rem - LEN_W'(1);
            if (last_word) begin
              state      <= S_DONE;
              DONE       <= 1'b1;
              CS_BAR_OUT <= 1'b1;
              DQ_OE      <= 1'b0;
            end else begin
              state       <= S_W_WAIT;
              WDATA_READY <= 1'b1;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        S_R_SETUP: begin
          state <= S_R_WAIT;
          tmr   <= TMR_W'(RD_WAIT_CYC - 1);
        end

        S_R_WAIT: begin
          if (tmr_tc) begin
            state       <= S_R_NEXT;
            RDATA       <= DQ_IN;
            RDATA_VALID <= 1'b1;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        S_R_NEXT: begin
          addr <= addr_inc;
          rem  <= rem - LEN_W'(1);
          if (last_word) begin
            state      <= S_DONE;
            DONE       <= 1'b1;
            CS_BAR_OUT <= 1'b1;
            OE_BAR_OUT <= 1'b1;
          end else begin
            state <= S_R_SETUP;
            ADDR  <= addr_inc;
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          CMD_READY <= 1'b1;
        end

        default: begin
          state       <= S_IDLE;
          CMD_READY   <= 1'b1;
          WDATA_READY <= 1'b0;
          DQ_OE       <= 1'b0;
          OE_BAR_OUT  <= 1'b1;
          CS_BAR_OUT  <= 1'b1;
          WE_BAR_OUT  <= 1'b1;
        end
      endcase
    end
  end

endmodule
